// File: rtl/program_sequencer.sv
// program_sequencer: buffers a short {op,data} program and issues it to the cpu.
// Define COND_SKIP_EN to enable the SKIPZ (4'hE) conditional-skip opcode.
module program_sequencer #(
  parameter int         DEPTH       = 16,
  parameter int         AW          = 4,
  parameter int         EXEC_CYCLES = 3,
  parameter logic [3:0] HALT_OP     = 4'hF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [3:0]    ld_op,
  input  logic [7:0]    ld_data,
  input  logic          ld_clr,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step,
  input  logic          abort,
  input  logic          cf,
  input  logic          zf,
  output logic [3:0]    op_code,
  output logic [7:0]    ext_data,
  output logic          ex_btn,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  localparam int          CW       = $clog2(EXEC_CYCLES + 1);
  localparam logic [AW:0] LEN_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT,
    S_NEXT, S_PAUSE, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [3:0]    op_q, op_d;
  logic [7:0]    data_q, data_d;
  logic          ex_btn_q, ex_btn_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   mem_q [DEPTH];
  logic          wr_en;
  logic [11:0]   cur;
  logic          last;
  logic          unused_flags;

  assign cur      = mem_q[pc_q];
  assign last     = ({1'b0, pc_q} == len_q - ONE);
  assign ld_ready = (state_q == S_IDLE) && (len_q < LEN_FULL) && !start;

`ifdef COND_SKIP_EN
  logic [AW:0] skip_tgt;
  assign skip_tgt     = {1'b0, pc_q} + (zf ? (AW+1)'(2) : ONE);
  assign unused_flags = cf;
`else
  assign unused_flags = cf ^ zf;
`endif

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    pc_d     = pc_q;
    op_d     = op_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    ex_btn_d = 1'b0;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld_clr) begin
          len_d = '0;
        end else if (ld_valid && ld_ready) begin
          wr_en = 1'b1;
          len_d = len_q + ONE;
        end
        // a same-cycle clear empties the program, so it cancels start
        if (start && !ld_clr && len_q != '0) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        if (cur[11:8] == HALT_OP) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
`ifdef COND_SKIP_EN
        else if (cur[11:8] == 4'hE) begin
          if (skip_tgt > len_q - ONE) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            pc_d    = skip_tgt[AW-1:0];
            state_d = step_mode ? S_PAUSE : S_FETCH;
          end
        end
`endif
        else begin
          op_d     = cur[11:8];
          data_d   = cur[7:0];
          ex_btn_d = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CW'(EXEC_CYCLES - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_NEXT;
        else cnt_d = cnt_q - CW'(1);
      end
      S_NEXT: begin
        if (last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          pc_d    = pc_q + AW'(1);
          state_d = step_mode ? S_PAUSE : S_FETCH;
        end
      end
      S_PAUSE: if (step) state_d = S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      ex_btn_d = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      pc_q     <= '0;
      op_q     <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      ex_btn_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      pc_q     <= pc_d;
      op_q     <= op_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      ex_btn_q <= ex_btn_d;
      done_q   <= done_d;
    end
  end

  // program words are invalidated by len, so storage needs no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[len_q[AW-1:0]] <= {ld_op, ld_data};
  end

  assign op_code  = op_q;
  assign ext_data = data_q;
  assign ex_btn   = ex_btn_q;
  assign pc       = pc_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: scoreboard bench for program_sequencer.
// Issued {op,data} words are checked against a queue filled at load time.
module tb_program_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [3:0]    ld_op = '0;
  logic [7:0]    ld_data = '0;
  logic          ld_clr = 1'b0;
  logic          start = 1'b0;
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
  logic          abort = 1'b0;
  logic          cf = 1'b0;
  logic          zf = 1'b0;
  logic [3:0]    op_code;
  logic [7:0]    ext_data;
  logic          ex_btn;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;

  program_sequencer #(
    .DEPTH(DEPTH), .AW(AW), .EXEC_CYCLES(3), .HALT_OP(4'hF)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_op(ld_op), .ld_data(ld_data), .ld_clr(ld_clr),
    .start(start), .step_mode(step_mode), .step(step),
    .abort(abort), .cf(cf), .zf(zf),
    .op_code(op_code), .ext_data(ext_data), .ex_btn(ex_btn),
    .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          n_pulse = 0;
  int          n_done  = 0;
  int          done_cyc = 0;
  logic [AW-1:0] done_pc;
  logic [11:0] exp_q[$];

  always @(posedge clk) cyc++;

  // scoreboard: every ex_btn pulse must match the next expected word
  always @(negedge clk) begin
    if (ex_btn === 1'b1) begin
      logic [11:0] e;
      n_pulse++;
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got %h%h, expected no issue", op_code, ext_data);
      end else begin
        e = exp_q.pop_front();
        if ({op_code, ext_data} !== e) begin
          errors++;
          $display("FAIL sb_word: got %h%h, expected %h", op_code, ext_data, e);
        end
      end
    end
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
      done_pc  = pc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] op, input logic [7:0] d);
    ld_valid = 1'b1;
    ld_op    = op;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic clear();
    ld_clr = 1'b1;
    tick();
    ld_clr = 1'b0;
  endtask

  task automatic kick(output int c0);
    start = 1'b1;
    c0    = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (busy === 1'b0) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if ({busy, ex_btn, done, op_code, ext_data, pc, ld_ready} !==
        {1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset: busy=%b ex=%b done=%b op=%h d=%h pc=%h rdy=%b, expected 0 0 0 0 00 0 1",
               busy, ex_btn, done, op_code, ext_data, pc, ld_ready);
    end
  endtask

  task automatic test_basic();
    int c0;
    logic [3:0] eop;
    clear();
    load(4'h1, 8'h05); exp_q.push_back(12'h105);
    load(4'h2, 8'h03); exp_q.push_back(12'h203);
    load(4'h3, 8'h00); exp_q.push_back(12'h300);
    kick(c0);
    for (int t = 1; t <= 20; t++) begin
      if (t >= 2 && t <= 18) begin
        eop = 4'(1 + (t - 2) / 6);
        vectors++;
        if (op_code !== eop) begin
          errors++;
          $display("FAIL basic_op c%0d: got %h, expected %h", t, op_code, eop);
        end
      end
      vectors++;
      if (ex_btn !== (t == 2 || t == 8 || t == 14)) begin
        errors++;
        $display("FAIL basic_exbtn c%0d: got %b", t, ex_btn);
      end
      vectors++;
      if (done !== (t == 19)) begin
        errors++;
        $display("FAIL basic_done c%0d: got %b", t, done);
      end
      vectors++;
      if (busy !== (t <= 19)) begin
        errors++;
        $display("FAIL basic_busy c%0d: got %b", t, busy);
      end
      if (t < 20) tick();
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_left: %0d words not issued, expected 0", exp_q.size());
    end
  endtask

  task automatic test_halt();
    int c0, p0, d0;
    bit ok;
    clear();
    load(4'h1, 8'hAA); exp_q.push_back(12'h1AA);
    load(4'hF, 8'h00);
    load(4'h2, 8'hBB);
    p0 = n_pulse;
    d0 = n_done;
    kick(c0);
    wait_idle(40, ok);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL halt_timeout: busy=%b, expected 0", busy);
    end
    vectors++;
    if (n_pulse - p0 != 1) begin
      errors++;
      $display("FAIL halt_pulses: got %0d, expected 1", n_pulse - p0);
    end
    vectors++;
    if (n_done - d0 != 1 || done_cyc - c0 != 8 || done_pc !== 4'd1) begin
      errors++;
      $display("FAIL halt_done: n=%0d cyc=%0d pc=%0d, expected 1 8 1",
               n_done - d0, done_cyc - c0, done_pc);
    end
  endtask

  task automatic test_full();
    int acc = 0;
    int p0;
    clear();
    for (int i = 0; i < DEPTH + 2; i++) begin
      ld_valid = 1'b1;
      ld_op    = 4'(i);
      ld_data  = 8'(i * 7);
      if (ld_ready === 1'b1) acc++;
      tick();
    end
    ld_valid = 1'b0;
    vectors++;
    if (acc != DEPTH) begin
      errors++;
      $display("FAIL full_count: got %0d, expected %0d", acc, DEPTH);
    end
    vectors++;
    if (ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got %b, expected 0", ld_ready);
    end
    clear();
    vectors++;
    if (ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_ready: got %b, expected 1", ld_ready);
    end
    p0 = n_pulse;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL empty_start: busy=%b, expected 0", busy);
      end
      tick();
    end
    vectors++;
    if (n_pulse != p0) begin
      errors++;
      $display("FAIL empty_pulse: got %0d, expected 0", n_pulse - p0);
    end
  endtask

  task automatic test_step();
    int c0, p0, d0;
    bit ok;
    clear();
    load(4'h3, 8'h31); exp_q.push_back(12'h331);
    load(4'h4, 8'h42); exp_q.push_back(12'h442);
    load(4'h5, 8'h53); exp_q.push_back(12'h553);
    step_mode = 1'b1;
    p0 = n_pulse;
    d0 = n_done;
    kick(c0);
    for (int k = 1; k <= 2; k++) begin
      repeat (10) tick();
      vectors++;
      if (n_pulse - p0 != k || busy !== 1'b1 || n_done != d0) begin
        errors++;
        $display("FAIL step_pause%0d: pulses=%0d busy=%b done=%0d, expected %0d 1 0",
                 k, n_pulse - p0, busy, n_done - d0, k);
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      vectors++;
      if (ex_btn !== 1'b0) begin
        errors++;
        $display("FAIL step_fetch%0d: ex_btn=%b, expected 0", k, ex_btn);
      end
      tick();
      vectors++;
      if (ex_btn !== 1'b1) begin
        errors++;
        $display("FAIL step_issue%0d: ex_btn=%b, expected 1", k, ex_btn);
      end
    end
    wait_idle(40, ok);
    step_mode = 1'b0;
    vectors++;
    if (!ok || n_done - d0 != 1 || n_pulse - p0 != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL step_end: ok=%b done=%0d pulses=%0d left=%0d, expected 1 1 3 0",
               ok, n_done - d0, n_pulse - p0, exp_q.size());
    end
  endtask

  task automatic test_abort();
    int c0, p0, d0;
    clear();
    load(4'h6, 8'h61); exp_q.push_back(12'h661);
    load(4'h7, 8'h72); exp_q.push_back(12'h772);
    load(4'h8, 8'h83);
    p0 = n_pulse;
    d0 = n_done;
    kick(c0);
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || ex_btn !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b ex=%b, expected 0 0", busy, ex_btn);
    end
    repeat (20) tick();
    vectors++;
    if (n_pulse - p0 != 2 || n_done != d0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_after: pulses=%0d done=%0d left=%0d, expected 2 0 0",
               n_pulse - p0, n_done - d0, exp_q.size());
    end
    exp_q.push_back(12'h661);
    kick(c0);
    tick();
    vectors++;
    if (ex_btn !== 1'b1) begin
      errors++;
      $display("FAIL rerun_issue: ex_btn=%b, expected 1", ex_btn);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({busy, ex_btn, done, op_code, ext_data, pc} !== 19'h0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b ex=%b done=%b op=%h d=%h pc=%h, expected all 0",
               busy, ex_btn, done, op_code, ext_data, pc);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_len: busy=%b after start, expected 0", busy);
    end
  endtask

  task automatic test_op_e();
    int c0, p0;
    bit ok;
`ifdef COND_SKIP_EN
    for (int z = 1; z >= 0; z--) begin
      clear();
      load(4'hE, 8'h00);
      load(4'h1, 8'h11);
      load(4'h2, 8'h22);
      if (z == 0) exp_q.push_back(12'h111);
      exp_q.push_back(12'h222);
      zf = z[0];
      p0 = n_pulse;
      kick(c0);
      wait_idle(40, ok);
      vectors++;
      if (!ok || n_pulse - p0 != 2 - z || exp_q.size() != 0) begin
        errors++;
        $display("FAIL skipz_zf%0d: ok=%b pulses=%0d left=%0d, expected 1 %0d 0",
                 z, ok, n_pulse - p0, exp_q.size(), 2 - z);
      end
    end
    zf = 1'b0;
`else
    clear();
    load(4'hE, 8'h00); exp_q.push_back(12'hE00);
    load(4'h1, 8'h11); exp_q.push_back(12'h111);
    load(4'h2, 8'h22); exp_q.push_back(12'h222);
    zf = 1'b1;
    p0 = n_pulse;
    kick(c0);
    wait_idle(40, ok);
    zf = 1'b0;
    vectors++;
    if (!ok || n_pulse - p0 != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL op_e: ok=%b pulses=%0d left=%0d, expected 1 3 0",
               ok, n_pulse - p0, exp_q.size());
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_halt();
    test_full();
    test_step();
    test_abort();
    test_op_e();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
